// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Reduction stage of the dot-product path. Unsigned WL-bit products arrive as
// a valid/ready stream and are summed per frame into a WA-bit accumulator.
// When the frame's last beat is accepted, the total, the beat count and an
// overflow flag are presented one cycle later as a single output transaction.
//
// Parameters
//   WL : product (input) width, unsigned
//   WA : accumulator / output width (WA >= WL)
//   WC : beat-counter width (WC >= 2), count saturates at 2^WC-1
//
// Ports
//   clk       : clock, all state on the rising edge
//   rst_n     : synchronous active-low reset
//   clr       : abort the frame being accumulated (no effect on a pending result)
//   in_valid  : product beat valid
//   in_ready  : block can accept a beat
//   in_data   : unsigned product
//   in_last   : beat is the final one of its frame
//   out_valid : frame result valid
//   out_ready : consumer accepts the result
//   out_sum   : frame sum
//   out_count : beats in frame (saturating)
//   out_ovf   : sum carried out of WA bits at some point during the frame
//
// Build option
//   PRODUCT_ACC_SAT_EN : when defined, the accumulator clamps to 2^WA-1 on the
//                        first carry out and stays clamped for the rest of the
//                        frame; when undefined it wraps modulo 2^WA.
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int WL = 32,
    parameter int WA = 40,
    parameter int WC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WA-1:0] out_sum,
    output logic [WC-1:0] out_count,
    output logic          out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WA-1:0] ACC_ZERO = {WA{1'b0}};
    localparam logic [WA-1:0] ACC_MAX  = {WA{1'b1}};
    localparam logic [WC-1:0] CNT_ZERO = {WC{1'b0}};
    localparam logic [WC-1:0] CNT_MAX  = {WC{1'b1}};
    localparam logic [WC-1:0] CNT_ONE  = WC'(32'd1);

    state_t        state_r, state_nxt_s;
    logic [WA-1:0] acc_r, acc_nxt_s;
    logic [WC-1:0] cnt_r, cnt_nxt_s;
    logic          ovf_r, ovf_nxt_s;
    logic          out_valid_r, out_valid_nxt_s;
    logic [WA-1:0] out_sum_r, out_sum_nxt_s;
    logic [WC-1:0] out_count_r, out_count_nxt_s;
    logic          out_ovf_r, out_ovf_nxt_s;

    logic          in_ready_s;
    logic          beat_s;
    logic [WA-1:0] base_acc_s;
    logic [WC-1:0] base_cnt_s;
    logic          base_ovf_s;
    logic [WA:0]   sum_wide_s;
    logic          carry_s;
    logic [WA-1:0] acc_add_s;
    logic [WC-1:0] cnt_add_s;
    logic          ovf_add_s;

    // Input acceptance: in DONE a beat may only enter while the result retires.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_ACC:  in_ready_s = !clr;
            ST_DONE: in_ready_s = out_ready && !clr;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign in_ready = in_ready_s;
    assign beat_s   = in_valid && in_ready_s;

    // Accumulate datapath. A beat taken in DONE opens a new frame, so it is
    // added to a zero base instead of the (already reported) running state.
    always_comb begin
        if (state_r == ST_DONE) begin
            base_acc_s = ACC_ZERO;
            base_cnt_s = CNT_ZERO;
            base_ovf_s = 1'b0;
        end else begin
            base_acc_s = acc_r;
            base_cnt_s = cnt_r;
            base_ovf_s = ovf_r;
        end
        sum_wide_s = {1'b0, base_acc_s} + {{(WA + 1 - WL){1'b0}}, in_data};
        carry_s    = sum_wide_s[WA];
`ifdef PRODUCT_ACC_SAT_EN
        // Once clamped, any further non-zero beat carries again, so the clamp
        // holds for the rest of the frame without extra state.
        if (carry_s) begin
            acc_add_s = ACC_MAX;
        end else begin
            acc_add_s = sum_wide_s[WA-1:0];
        end
`else
        acc_add_s = sum_wide_s[WA-1:0];
`endif
        ovf_add_s = base_ovf_s | carry_s;
        if (base_cnt_s == CNT_MAX) begin
            cnt_add_s = CNT_MAX;
        end else begin
            cnt_add_s = base_cnt_s + CNT_ONE;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        ovf_nxt_s       = ovf_r;
        out_valid_nxt_s = out_valid_r;
        out_sum_nxt_s   = out_sum_r;
        out_count_nxt_s = out_count_r;
        out_ovf_nxt_s   = out_ovf_r;
        case (state_r)
            ST_ACC: begin
                if (clr) begin
                    acc_nxt_s = ACC_ZERO;
                    cnt_nxt_s = CNT_ZERO;
                    ovf_nxt_s = 1'b0;
                end else if (beat_s) begin
                    if (in_last) begin
                        state_nxt_s     = ST_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_sum_nxt_s   = acc_add_s;
                        out_count_nxt_s = cnt_add_s;
                        out_ovf_nxt_s   = ovf_add_s;
                        acc_nxt_s       = ACC_ZERO;
                        cnt_nxt_s       = CNT_ZERO;
                        ovf_nxt_s       = 1'b0;
                    end else begin
                        acc_nxt_s = acc_add_s;
                        cnt_nxt_s = cnt_add_s;
                        ovf_nxt_s = ovf_add_s;
                    end
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (beat_s && in_last) begin
                        // Single-beat frame right behind the retiring one.
                        state_nxt_s     = ST_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_sum_nxt_s   = acc_add_s;
                        out_count_nxt_s = cnt_add_s;
                        out_ovf_nxt_s   = ovf_add_s;
                        acc_nxt_s       = ACC_ZERO;
                        cnt_nxt_s       = CNT_ZERO;
                        ovf_nxt_s       = 1'b0;
                    end else if (beat_s) begin
                        state_nxt_s     = ST_ACC;
                        out_valid_nxt_s = 1'b0;
                        acc_nxt_s       = acc_add_s;
                        cnt_nxt_s       = cnt_add_s;
                        ovf_nxt_s       = ovf_add_s;
                    end else begin
                        state_nxt_s     = ST_ACC;
                        out_valid_nxt_s = 1'b0;
                        acc_nxt_s       = ACC_ZERO;
                        cnt_nxt_s       = CNT_ZERO;
                        ovf_nxt_s       = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s     = ST_ACC;
                acc_nxt_s       = ACC_ZERO;
                cnt_nxt_s       = CNT_ZERO;
                ovf_nxt_s       = 1'b0;
                out_valid_nxt_s = 1'b0;
                out_sum_nxt_s   = ACC_ZERO;
                out_count_nxt_s = CNT_ZERO;
                out_ovf_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            acc_r       <= ACC_ZERO;
            cnt_r       <= CNT_ZERO;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= ACC_ZERO;
            out_count_r <= CNT_ZERO;
            out_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ovf_r       <= ovf_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_sum_r   <= out_sum_nxt_s;
            out_count_r <= out_count_nxt_s;
            out_ovf_r   <= out_ovf_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_count = out_count_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer for the operand-pair multiplier stage. It takes the multiplier's unsigned WL-bit products as a valid/ready stream and sums them per frame into a WA-bit accumulator. When the frame's last product arrives, it presents the total, the beat count and an overflow flag as one output transaction. It is the reduction stage of the dot-product path.

Parameters:
WL, 32, product (input) width, unsigned
WA, 40, accumulator/output width; WA >= WL required
WC, 8, beat-counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset
clr  input  1  abort current frame, discard partial sum
in_valid  input  1  product beat valid
in_ready  output  1  block can accept beat
in_data  input  WL  unsigned product
in_last  input  1  beat is final of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_sum  output  WA  frame sum
out_count  output  WC  beats in frame (saturating)
out_ovf  output  1  sum overflowed during frame

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All state is on the rising edge of clk.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Two states: ACC and DONE.
- ACC:
  - in_ready = !clr.
  - On beat (in_valid && in_ready), in_data is zero-extended to WA+1 bits and added to acc.
  - cnt increments, saturating at 2^WC-1.
  - ovf is set sticky if the add carries out of WA bits.
- Beat with in_last=1:
  - Next cycle: state=DONE, out_valid=1.
  - out_sum, out_count and out_ovf are registered and include that beat.
  - Latency: result valid 1 cycle after the last beat handshake.
- DONE:
  - out_* held stable while out_valid && !out_ready.
  - in_ready = out_ready && !clr.
  - If out_ready=1, the result is retired. A beat accepted in the same cycle starts the new frame: acc=in_data, cnt=1, ovf=0, and the state goes to ACC.
  - If that beat also has in_last=1, the state stays DONE with the new result; out_valid stays 1 (back-to-back single-beat frames).
  - If out_ready=1 with no beat: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0.
- clr, in ACC: acc, cnt and ovf go to 0 next cycle. No beat is accepted that cycle.
- clr, in DONE: does not cancel the pending result. It only blocks input.
- rst_n low mid-frame or with a result pending: the partial sum and the pending result are lost and all reset values apply.
- Empty frame does not exist; a frame is at least one beat.
- out_count saturation does not affect acc or ovf.
- Overflow without the optional feature: acc wraps modulo 2^WA.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- Defined:
  - On carry out of WA bits, acc clamps to 2^WA-1.
  - acc stays clamped for all further beats of the frame.
  - out_ovf=1.
- Undefined:
  - acc wraps modulo 2^WA.
  - out_ovf=1 still indicates that any carry out occurred.

Test Plan:
- Beats 3, 5, 7 (last on 7), out_ready=1 -> one cycle after the 7 handshake: out_valid=1, out_sum=15, out_count=3, out_ovf=0.
- Frame 2, 2 (last), then out_ready=0 for 4 cycles -> out_sum=4 held stable, in_ready=0. Then out_ready=1 together with beat 9 (last) -> next cycle out_sum=9, out_count=1, out_valid still 1.
- WA=32: beats 0xFFFFFFFF, 2 (last) -> without macro out_sum=0x00000001, out_ovf=1. With PRODUCT_ACC_SAT_EN, out_sum=0xFFFFFFFF, out_ovf=1.
- Beats 10, 20, then clr for 1 cycle with in_valid=1 (beat not accepted, in_ready=0), then 4 (last) -> out_sum=4, out_count=1.
- WC=8: 300 beats of 1, last on 300th -> out_count=255, out_sum=300, out_ovf=0.
- rst_n low for 1 cycle after beats 6, 6 -> all outputs 0. Then 1 (last) -> out_sum=1, out_count=1.
